wb_arbiter: RTL and testbench



---
 rtl/wb_arbiter_pkg.sv | 18 +
 rtl/wb_arbiter_if.sv | 40 ++++
 rtl/wb_arbiter_fifo.sv | 56 +++++
 rtl/wb_arbiter.sv | 144 ++++++++++++++
 tb/tb_wb_arbiter.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared types and default parameter values for the multi-source writeback arbiter.
// wb_entry_t is the default-width payload carried through each source FIFO.
package wb_arbiter_pkg;

  localparam int NUM_SRC_DEF    = 3;
  localparam int DATA_W_DEF     = 32;
  localparam int RADDR_W_DEF    = 5;
  localparam int FIFO_DEPTH_DEF = 2;

  typedef struct packed {
    logic [RADDR_W_DEF-1:0] rd;
    logic [DATA_W_DEF-1:0]  data;
    logic                   to_reg;
    logic                   to_freg;
    logic                   is_jump;
  } wb_entry_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Source-side result handshake plus register-file write / commit report of the writeback stage.
// The arbiter takes the slave view; execution units and control logic take the master view.
interface wb_arbiter_if
  import wb_arbiter_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RADDR_W = RADDR_W_DEF
);
  localparam int SEL_W = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0]              src_valid;
  logic [NUM_SRC-1:0]              src_ready;
  logic [NUM_SRC-1:0][RADDR_W-1:0] src_rd;
  logic [NUM_SRC-1:0][DATA_W-1:0]  src_data;
  logic [NUM_SRC-1:0]              src_to_reg;
  logic [NUM_SRC-1:0]              src_to_freg;
  logic [NUM_SRC-1:0]              src_is_jump;

  logic                            reg_w_enable;
  logic                            freg_w_enable;
  logic [RADDR_W-1:0]              reg_w_dest;
  logic [DATA_W-1:0]               reg_w_data;
  logic                            commit_valid;
  logic [SEL_W-1:0]                commit_src;
  logic                            is_jump_chosen_n;

  modport slave (
    input  src_valid, src_rd, src_data, src_to_reg, src_to_freg, src_is_jump,
    output src_ready, reg_w_enable, freg_w_enable, reg_w_dest, reg_w_data,
           commit_valid, commit_src, is_jump_chosen_n
  );

  modport master (
    output src_valid, src_rd, src_data, src_to_reg, src_to_freg, src_is_jump,
    input  src_ready, reg_w_enable, freg_w_enable, reg_w_dest, reg_w_data,
           commit_valid, commit_src, is_jump_chosen_n
  );

endinterface

// File: rtl/wb_arbiter_fifo.sv
// wb_fifo: small synchronous FIFO holding completed results of one execution unit.
// Push and pop in the same cycle are both honoured; flush and rst empty it.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int  DEPTH   = FIFO_DEPTH_DEF,
  parameter type entry_t = wb_entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   flush,
  input  logic   push,
  input  entry_t push_entry,
  input  logic   pop,
  output entry_t head,
  output logic   full,
  output logic   empty
);
  localparam int AW = $clog2(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; the pointers alone decide which slots hold live entries.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: NUM_SRC result FIFOs drained round-robin onto one register-file write port.
// Define WB_PERF_EN to add the perf_commit_cnt / perf_stall_cnt counter outputs.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NUM_SRC    = NUM_SRC_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int RADDR_W    = RADDR_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
`ifdef WB_PERF_EN
  output logic [31:0] perf_commit_cnt,
  output logic [31:0] perf_stall_cnt,
`endif
  wb_arbiter_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_SRC);

  typedef struct packed {
    logic [RADDR_W-1:0] rd;
    logic [DATA_W-1:0]  data;
    logic               to_reg;
    logic               to_freg;
    logic               is_jump;
  } entry_t;

  entry_t             in_entry [NUM_SRC];
  entry_t             head     [NUM_SRC];
  entry_t             win;
  logic [NUM_SRC-1:0] full;
  logic [NUM_SRC-1:0] empty;
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] pop;
  logic [SEL_W-1:0]   last_grant;
  logic [SEL_W-1:0]   grant;
  logic               grant_valid;

  // Ready depends only on FIFO state, never on the pop being decided this cycle.
  assign bus.src_ready = ~full;
  assign push          = bus.src_valid & ~full;

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      in_entry[i] = '{rd:      bus.src_rd[i],
                      data:    bus.src_data[i],
                      to_reg:  bus.src_to_reg[i],
                      to_freg: bus.src_to_freg[i],
                      is_jump: bus.src_is_jump[i]};
    end
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_fifo
    wb_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .entry_t (entry_t)
    ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .push       (push[g]),
      .push_entry (in_entry[g]),
      .pop        (pop[g]),
      .head       (head[g]),
      .full       (full[g]),
      .empty      (empty[g])
    );
  end

  // Round-robin: sources above last_grant first, then wrap to the lower ones.
  // NOTE: every combinational output gets a default before any branch so no latch is inferred.
  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!grant_valid && i > int'(last_grant) && !empty[i]) begin
        grant_valid = 1'b1;
        grant       = SEL_W'(i);
      end
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!grant_valid && i <= int'(last_grant) && !empty[i]) begin
        grant_valid = 1'b1;
        grant       = SEL_W'(i);
      end
    end
  end

  always_comb begin
    pop = '0;
    if (grant_valid) pop[grant] = 1'b1;
    win = head[grant];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= SEL_W'(NUM_SRC - 1);
    end else if (grant_valid && !flush) begin
      last_grant <= grant;
    end
  end

  // Output register: one-cycle commit pulse; dest/data hold while idle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      bus.commit_valid     <= 1'b0;
      bus.commit_src       <= '0;
      bus.is_jump_chosen_n <= 1'b0;
      bus.reg_w_enable     <= 1'b0;
      bus.freg_w_enable    <= 1'b0;
      bus.reg_w_dest       <= '0;
      bus.reg_w_data       <= '0;
    end else if (grant_valid) begin
      bus.commit_valid     <= 1'b1;
      bus.commit_src       <= grant;
      bus.is_jump_chosen_n <= win.is_jump;
      bus.reg_w_enable     <= win.to_reg && !win.to_freg && (win.rd != '0);
      bus.freg_w_enable    <= win.to_freg;
      bus.reg_w_dest       <= win.rd;
      bus.reg_w_data       <= win.data;
    end else begin
      bus.commit_valid     <= 1'b0;
      bus.commit_src       <= '0;
      bus.is_jump_chosen_n <= 1'b0;
      bus.reg_w_enable     <= 1'b0;
      bus.freg_w_enable    <= 1'b0;
    end
  end

`ifdef WB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_commit_cnt <= '0;
      perf_stall_cnt  <= '0;
    end else begin
      if (bus.commit_valid)            perf_commit_cnt <= perf_commit_cnt + 32'd1;
      if (|(bus.src_valid & full))     perf_stall_cnt  <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: latency, x0/FP enables, round-robin, backpressure, flush/reset, jump flag.
// Status vector compared below is {commit_valid, commit_src[1:0], reg_w_enable, freg_w_enable, is_jump_chosen_n}.
module tb_wb_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  wb_arbiter_if #(.NUM_SRC(3), .DATA_W(32), .RADDR_W(5)) bus ();

`ifdef WB_PERF_EN
  logic [31:0] perf_commit_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  wb_arbiter #(.NUM_SRC(3), .DATA_W(32), .RADDR_W(5), .FIFO_DEPTH(2)) u_dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
`ifdef WB_PERF_EN
    .perf_commit_cnt (perf_commit_cnt),
    .perf_stall_cnt  (perf_stall_cnt),
`endif
    .bus             (bus)
  );

  function automatic logic [5:0] status();
    return {bus.commit_valid, bus.commit_src, bus.reg_w_enable,
            bus.freg_w_enable, bus.is_jump_chosen_n};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.src_valid   = '0;
    bus.src_rd      = '0;
    bus.src_data    = '0;
    bus.src_to_reg  = '0;
    bus.src_to_freg = '0;
    bus.src_is_jump = '0;
  endtask

  task automatic set_src(input int s, input logic [4:0] rd, input logic [31:0] data,
                         input logic to_reg, input logic to_freg, input logic is_jump);
    bus.src_valid[s]   = 1'b1;
    bus.src_rd[s]      = rd;
    bus.src_data[s]    = data;
    bus.src_to_reg[s]  = to_reg;
    bus.src_to_freg[s] = to_freg;
    bus.src_is_jump[s] = is_jump;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; idle();
    tick(); tick();
    rst = 1'b0;
    checks++;
    if (status() !== 6'b0) begin
      errors++; $display("FAIL reset_status: got %b expected %b", status(), 6'b0);
    end
    checks++;
    if ({bus.reg_w_dest, bus.reg_w_data} !== 37'h0) begin
      errors++; $display("FAIL reset_dest_data: got %h/%h expected 0/0", bus.reg_w_dest, bus.reg_w_data);
    end
    checks++;
    if (bus.src_ready !== 3'b111) begin
      errors++; $display("FAIL reset_ready: got %b expected 111", bus.src_ready);
    end
  endtask

  task automatic test_single();
    set_src(0, 5'd5, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
    tick(); idle();
    checks++;
    if (status() !== 6'b0) begin
      errors++; $display("FAIL single_t1: got %b expected %b", status(), 6'b0);
    end
    tick();
    checks++;
    if (status() !== 6'b1_00_1_0_0) begin
      errors++; $display("FAIL single_t2: got %b expected %b", status(), 6'b100100);
    end
    checks++;
    if ({bus.reg_w_dest, bus.reg_w_data} !== {5'd5, 32'hDEADBEEF}) begin
      errors++; $display("FAIL single_dest_data: got %h/%h expected 05/deadbeef", bus.reg_w_dest, bus.reg_w_data);
    end
    tick();
    checks++;
    if (status() !== 6'b0) begin
      errors++; $display("FAIL single_t3: got %b expected %b", status(), 6'b0);
    end
    checks++;
    if ({bus.reg_w_dest, bus.reg_w_data} !== {5'd5, 32'hDEADBEEF}) begin
      errors++; $display("FAIL single_hold: got %h/%h expected 05/deadbeef", bus.reg_w_dest, bus.reg_w_data);
    end
  endtask

  task automatic test_x0_fp();
    set_src(0, 5'd0, 32'h1234, 1'b1, 1'b0, 1'b0);
    tick();
    set_src(0, 5'd0, 32'h1, 1'b0, 1'b1, 1'b0);
    tick(); idle();
    checks++;
    if (status() !== 6'b1_00_0_0_0) begin
      errors++; $display("FAIL x0_suppress: got %b expected %b", status(), 6'b100000);
    end
    tick();
    checks++;
    if (status() !== 6'b1_00_0_1_0) begin
      errors++; $display("FAIL f0_write: got %b expected %b", status(), 6'b100010);
    end
    checks++;
    if ({bus.reg_w_dest, bus.reg_w_data} !== {5'd0, 32'h1}) begin
      errors++; $display("FAIL f0_dest_data: got %h/%h expected 00/00000001", bus.reg_w_dest, bus.reg_w_data);
    end
    tick();
  endtask

  task automatic test_jump();
    set_src(2, 5'd3, 32'hCAFE, 1'b1, 1'b0, 1'b1);
    tick(); idle();
    tick();
    checks++;
    if (status() !== 6'b1_10_1_0_1) begin
      errors++; $display("FAIL jump_commit: got %b expected %b", status(), 6'b110101);
    end
    tick();
    checks++;
    if (status() !== 6'b0) begin
      errors++; $display("FAIL jump_idle: got %b expected %b", status(), 6'b0);
    end
  endtask

  // All three sources push for 9 edges; last grant was source 2, so commits run 0,1,2,...
  task automatic test_contention();
    logic [5:0] exp_st;
    logic [1:0] exp_src;
    for (int k = 1; k <= 16; k++) begin
      idle();
      if (k <= 9) begin
        for (int s = 0; s < 3; s++) set_src(s, 5'(s + 1), {8'(s), 24'(k)}, 1'b1, 1'b0, 1'b0);
      end
      tick();
      if (k >= 2 && k <= 14) begin
        exp_src = 2'((k - 2) % 3);
        exp_st  = {1'b1, exp_src, 3'b100};
        checks++;
        if (bus.reg_w_data[31:24] !== {6'b0, exp_src}) begin
          errors++; $display("FAIL rr_data_src k=%0d: got %h expected %h", k, bus.reg_w_data[31:24], exp_src);
        end
      end else begin
        exp_st = 6'b0;
      end
      checks++;
      if (status() !== exp_st) begin
        errors++; $display("FAIL rr_status k=%0d: got %b expected %b", k, status(), exp_st);
      end
      if (k == 2) begin
        checks++;
        if (bus.src_ready !== 3'b001) begin
          errors++; $display("FAIL rr_ready_full: got %b expected 001", bus.src_ready);
        end
      end
    end
    idle();
  endtask

  // src1 fills while src0 shares grants; the held push (0x1D) must enter exactly once.
  task automatic test_backpressure();
    logic [5:0]  exp_st [8];
    logic [31:0] exp_d  [8];
    exp_st = '{6'b0, 6'b1_01_100, 6'b1_00_100, 6'b1_01_100,
               6'b1_00_100, 6'b1_01_100, 6'b1_01_100, 6'b0};
    exp_d  = '{32'h0, 32'h1A, 32'hA0, 32'h1B, 32'hB0, 32'h1C, 32'h1D, 32'h0};
    for (int k = 1; k <= 8; k++) begin
      idle();
      case (k)
        1: begin set_src(0, 5'd7, 32'hA0, 1'b1, 1'b0, 1'b0); set_src(1, 5'd7, 32'h1A, 1'b1, 1'b0, 1'b0); end
        2: begin set_src(0, 5'd7, 32'hB0, 1'b1, 1'b0, 1'b0); set_src(1, 5'd7, 32'h1B, 1'b1, 1'b0, 1'b0); end
        3: set_src(1, 5'd7, 32'h1C, 1'b1, 1'b0, 1'b0);
        4, 5: set_src(1, 5'd7, 32'h1D, 1'b1, 1'b0, 1'b0);
        default: ;
      endcase
      tick();
      checks++;
      if (status() !== exp_st[k-1]) begin
        errors++; $display("FAIL bp_status k=%0d: got %b expected %b", k, status(), exp_st[k-1]);
      end
      if (exp_st[k-1][5]) begin
        checks++;
        if (bus.reg_w_data !== exp_d[k-1]) begin
          errors++; $display("FAIL bp_data k=%0d: got %h expected %h", k, bus.reg_w_data, exp_d[k-1]);
        end
      end
      if (k == 3 || k == 4) begin
        checks++;
        if (bus.src_ready[1] !== (k == 4)) begin
          errors++; $display("FAIL bp_ready1 k=%0d: got %b expected %b", k, bus.src_ready[1], (k == 4));
        end
      end
    end
    idle();
  endtask

  task automatic test_flush(input logic use_rst);
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < 3; s++) set_src(s, 5'd9, 32'h5500 + 32'(s), 1'b1, 1'b0, 1'b0);
      tick();
    end
    checks++;
    if (bus.commit_valid !== 1'b1) begin
      errors++; $display("FAIL flush_pre rst=%0b: got commit_valid %b expected 1", use_rst, bus.commit_valid);
    end
    for (int s = 0; s < 3; s++) set_src(s, 5'd10, 32'h7700 + 32'(s), 1'b1, 1'b0, 1'b0);
    if (use_rst) rst = 1'b1; else flush = 1'b1;
    tick();
    rst = 1'b0; flush = 1'b0; idle();
    checks++;
    if (status() !== 6'b0) begin
      errors++; $display("FAIL flush_status rst=%0b: got %b expected %b", use_rst, status(), 6'b0);
    end
    checks++;
    if (bus.src_ready !== 3'b111) begin
      errors++; $display("FAIL flush_ready rst=%0b: got %b expected 111", use_rst, bus.src_ready);
    end
    if (use_rst) begin
      checks++;
      if ({bus.reg_w_dest, bus.reg_w_data} !== 37'h0) begin
        errors++; $display("FAIL rst_dest_data: got %h/%h expected 0/0", bus.reg_w_dest, bus.reg_w_data);
      end
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (bus.commit_valid !== 1'b0) begin
        errors++; $display("FAIL flush_drop rst=%0b cyc=%0d: got commit_valid %b expected 0", use_rst, k, bus.commit_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_x0_fp();
    test_jump();
    test_contention();
    test_backpressure();
    test_flush(1'b0);
    test_flush(1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

endmodule
